// File: rtl/impl_checker.sv
// Checker for the implication "a |-> ##DELAY b": tracks overlapping obligations,
// reports pass/fail pulses, keeps saturating event counters and the first failing cycle.
module impl_checker #(
  parameter int unsigned DELAY        = 1,
  parameter int unsigned CW           = 16,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          disable_chk,
  input  logic          clear,
  input  logic          a,
  input  logic          b,
  output logic          pass,
  output logic          fail,
  output logic          busy,
  output logic [CW-1:0] trig_count,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] fail_count,
  output logic [CW-1:0] abort_count,
  output logic          first_fail_valid,
  output logic [CW-1:0] first_fail_cycle,
  output logic          halted
);

  // Pending depth is at most 8, so a 4-bit population count is enough.
  localparam int unsigned PCW = 4;
  localparam int unsigned SW  = CW + PCW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  logic [DELAY-1:0] r_pend;
  logic [CW-1:0]    r_cyc;
  logic [CW-1:0]    r_trig_cnt;
  logic [CW-1:0]    r_pass_cnt;
  logic [CW-1:0]    r_fail_cnt;
  logic [CW-1:0]    r_abort_cnt;
  logic [CW-1:0]    r_ff_cycle;
  logic             r_ff_valid;
  logic             r_pass;
  logic             r_fail;

  logic             w_run;
  logic             w_mature;
  logic             w_create;
  logic             w_eval;
  logic             w_pass;
  logic             w_fail;
  logic             w_halt;
  logic [PCW-1:0]   w_pend_cnt;
  logic [DELAY-1:0] w_pend_shift;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] v, input logic [PCW-1:0] inc);
    logic [SW-1:0] s;
    s = SW'(v) + SW'(inc);
    return (s > SW'({CW{1'b1}})) ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  // Obligation bookkeeping: bit 0 is the newest, bit DELAY-1 matures at the coming edge.
  always_comb begin
    w_pend_cnt   = PCW'($countones(r_pend));
    w_run        = (r_state == ST_RUN);
    w_mature     = r_pend[DELAY-1];
    w_create     = a & enable & ~disable_chk & w_run;
    w_eval       = w_mature & ~disable_chk & (r_state != ST_HALTED);
    w_pass       = w_eval & b;
    w_fail       = w_eval & ~b;
    w_halt       = STOP_ON_FAIL & w_fail & w_run;
    w_pend_shift = DELAY'({r_pend, w_create});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_cyc       <= '0;
      r_trig_cnt  <= '0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_abort_cnt <= '0;
      r_ff_cycle  <= '0;
      r_ff_valid  <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_cyc       <= '0;
      r_trig_cnt  <= '0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_abort_cnt <= '0;
      r_ff_cycle  <= '0;
      r_ff_valid  <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_cyc  <= sat_add(r_cyc, PCW'(1));
      r_pass <= w_pass;
      r_fail <= w_fail;

      if (w_create) r_trig_cnt <= sat_add(r_trig_cnt, PCW'(1));
      if (w_pass)   r_pass_cnt <= sat_add(r_pass_cnt, PCW'(1));
      if (w_fail) begin
        r_fail_cnt <= sat_add(r_fail_cnt, PCW'(1));
        if (!r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_cycle <= r_cyc;
        end
      end
      if (disable_chk) r_abort_cnt <= sat_add(r_abort_cnt, w_pend_cnt);

      // Abort and halt both flush; only the abort path is counted.
      if (disable_chk || w_halt || (r_state == ST_HALTED)) r_pend <= '0;
      else                                                  r_pend <= w_pend_shift;

      case (r_state)
        ST_IDLE:   if (enable) r_state <= ST_RUN;
        ST_RUN: begin
          if (w_halt)                r_state <= ST_HALTED;
          else if (!enable && !busy) r_state <= ST_IDLE;
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy             = |r_pend;
  assign halted           = (r_state == ST_HALTED);
  assign pass             = r_pass;
  assign fail             = r_fail;
  assign trig_count       = r_trig_cnt;
  assign pass_count       = r_pass_cnt;
  assign fail_count       = r_fail_cnt;
  assign abort_count      = r_abort_cnt;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_cycle = r_ff_cycle;

endmodule

// File: tb/tb_impl_checker.sv
// Two checker instances (DELAY=3/CW=16 free-running, DELAY=1/CW=5 stop-on-fail) share
// one stimulus stream; an obligation-queue model predicts pulses and counters.
module tb_impl_checker;

  localparam int D0 = 3;
  localparam int D1 = 1;
  localparam int CW0 = 16;
  localparam int CW1 = 5;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk, rst_n, en, dis, clr, a, b;

  logic        pass0, fail0, busy0, ffv0, halted0;
  logic [15:0] trig0, passc0, failc0, abort0, ffc0;
  logic        pass1, fail1, busy1, ffv1, halted1;
  logic [4:0]  trig1, passc1, failc1, abort1, ffc1;

  impl_checker #(.DELAY(D0), .CW(CW0), .STOP_ON_FAIL(1'b0)) u_dut0 (
    .clock(clk), .reset_n(rst_n), .enable(en), .disable_chk(dis), .clear(clr),
    .a(a), .b(b), .pass(pass0), .fail(fail0), .busy(busy0),
    .trig_count(trig0), .pass_count(passc0), .fail_count(failc0), .abort_count(abort0),
    .first_fail_valid(ffv0), .first_fail_cycle(ffc0), .halted(halted0)
  );

  impl_checker #(.DELAY(D1), .CW(CW1), .STOP_ON_FAIL(1'b1)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .enable(en), .disable_chk(dis), .clear(clr),
    .a(a), .b(b), .pass(pass1), .fail(fail1), .busy(busy1),
    .trig_count(trig1), .pass_count(passc1), .fail_count(failc1), .abort_count(abort1),
    .first_fail_valid(ffv1), .first_fail_cycle(ffc1), .halted(halted1)
  );

  int d_pass[2], d_fail[2], d_busy[2], d_halt[2], d_ffv[2];
  int d_trig[2], d_passc[2], d_failc[2], d_abort[2], d_ffc[2];
  assign d_pass[0]  = 32'(pass0);   assign d_pass[1]  = 32'(pass1);
  assign d_fail[0]  = 32'(fail0);   assign d_fail[1]  = 32'(fail1);
  assign d_busy[0]  = 32'(busy0);   assign d_busy[1]  = 32'(busy1);
  assign d_halt[0]  = 32'(halted0); assign d_halt[1]  = 32'(halted1);
  assign d_ffv[0]   = 32'(ffv0);    assign d_ffv[1]   = 32'(ffv1);
  assign d_trig[0]  = 32'(trig0);   assign d_trig[1]  = 32'(trig1);
  assign d_passc[0] = 32'(passc0);  assign d_passc[1] = 32'(passc1);
  assign d_failc[0] = 32'(failc0);  assign d_failc[1] = 32'(failc1);
  assign d_abort[0] = 32'(abort0);  assign d_abort[1] = 32'(abort1);
  assign d_ffc[0]   = 32'(ffc0);    assign d_ffc[1]   = 32'(ffc1);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tb_edge = 0;
  always @(posedge clk) tb_edge <= tb_edge + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int inst; int due; } ob_t;
  typedef struct { int inst; bit is_pass; int edge_n; } ev_t;

  ob_t ob_q[$];
  ev_t ev_q[$];
  int  m_t = 0;
  int  m_state[2], m_cyc[2], m_trig[2], m_pass[2], m_fail[2], m_abort[2], m_ffv[2], m_ffc[2];

  function automatic int p_d(int i);   return (i == 0) ? D0 : D1; endfunction
  function automatic int p_mx(int i);  return (i == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1; endfunction
  function automatic bit p_sof(int i); return (i == 1); endfunction

  function automatic int sat(int v, int inc, int mx);
    return (v + inc > mx) ? mx : v + inc;
  endfunction

  function automatic int m_busy(int i);
    int n = 0;
    foreach (ob_q[k]) if (ob_q[k].inst == i) n++;
    return (n > 0) ? 1 : 0;
  endfunction

  // Remove obligations of instance i; due_only < 0 removes all of them.
  task automatic drop(int i, int due_only);
    ob_t keep[$];
    foreach (ob_q[k])
      if (!(ob_q[k].inst == i && (due_only < 0 || ob_q[k].due == due_only))) keep.push_back(ob_q[k]);
    ob_q = keep;
  endtask

  task automatic model_zero(int i);
    m_state[i] = M_IDLE; m_cyc[i] = 0; m_trig[i] = 0; m_pass[i] = 0;
    m_fail[i] = 0; m_abort[i] = 0; m_ffv[i] = 0; m_ffc[i] = 0;
  endtask

  task automatic model_edge(int i, bit m_en, bit m_dis, bit m_clr, bit m_a, bit m_b);
    int  n_pend, mx;
    bit  matured, failed;
    ev_t e;
    ob_t o;
    mx = p_mx(i); n_pend = 0; matured = 0; failed = 0;
    foreach (ob_q[k]) if (ob_q[k].inst == i) begin
      n_pend++;
      if (ob_q[k].due == m_t) matured = 1;
    end
    if (m_clr) begin
      model_zero(i);
      drop(i, -1);
      return;
    end
    if (m_dis) begin
      m_abort[i] = sat(m_abort[i], n_pend, mx);
      drop(i, -1);
    end else if (matured) begin
      drop(i, m_t);
      e.inst = i; e.is_pass = m_b; e.edge_n = tb_edge;
      ev_q.push_back(e);
      if (m_b) m_pass[i] = sat(m_pass[i], 1, mx);
      else begin
        m_fail[i] = sat(m_fail[i], 1, mx);
        failed = 1;
        if (m_ffv[i] == 0) begin m_ffv[i] = 1; m_ffc[i] = m_cyc[i]; end
      end
    end
    if (m_a && m_en && !m_dis && m_state[i] == M_RUN) begin
      m_trig[i] = sat(m_trig[i], 1, mx);
      o.inst = i; o.due = m_t + p_d(i);
      ob_q.push_back(o);
    end
    if (m_state[i] == M_IDLE) begin
      if (m_en) m_state[i] = M_RUN;
    end else if (m_state[i] == M_RUN) begin
      if (failed && p_sof(i)) begin m_state[i] = M_HALT; drop(i, -1); end
      else if (!m_en && n_pend == 0) m_state[i] = M_IDLE;
    end
    m_cyc[i] = sat(m_cyc[i], 1, mx);
  endtask

  task automatic model_reset();
    model_zero(0);
    model_zero(1);
    ob_q.delete();
  endtask

  // ---------------- stimulus ----------------
  task automatic step(bit s_en, bit s_dis, bit s_clr, bit s_a, bit s_b);
    @(negedge clk);
    en = s_en; dis = s_dis; clr = s_clr; a = s_a; b = s_b;
    for (int i = 0; i < 2; i++) model_edge(i, s_en, s_dis, s_clr, s_a, s_b);
    m_t++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_pass%0d", i),  d_pass[i],  0);
      chk($sformatf("rst_fail%0d", i),  d_fail[i],  0);
      chk($sformatf("rst_busy%0d", i),  d_busy[i],  0);
      chk($sformatf("rst_halt%0d", i),  d_halt[i],  0);
      chk($sformatf("rst_trig%0d", i),  d_trig[i],  0);
      chk($sformatf("rst_passc%0d", i), d_passc[i], 0);
      chk($sformatf("rst_failc%0d", i), d_failc[i], 0);
      chk($sformatf("rst_abort%0d", i), d_abort[i], 0);
      chk($sformatf("rst_ffv%0d", i),   d_ffv[i],   0);
      chk($sformatf("rst_ffc%0d", i),   d_ffc[i],   0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  function automatic bit rnd(int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // ---------------- monitor ----------------
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("pass_fail_excl%0d", i), d_pass[i] & d_fail[i], 0);
        if (d_pass[i] != 0 || d_fail[i] != 0) begin
          if (ev_q.size() == 0) chk($sformatf("pulse_unexpected%0d", i), 1, 0);
          else begin
            e = ev_q.pop_front();
            chk($sformatf("pulse_inst%0d", i), i, e.inst);
            chk($sformatf("pulse_kind%0d", i), d_pass[i], 32'(e.is_pass));
            chk($sformatf("pulse_edge%0d", i), tb_edge - 1, e.edge_n);
          end
        end
      end
      while (ev_q.size() > 0 && ev_q[0].edge_n < tb_edge - 1) begin
        e = ev_q.pop_front();
        chk($sformatf("pulse_missing%0d", e.inst), 0, 1);
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i),   d_busy[i],  m_busy(i));
        chk($sformatf("halted%0d", i), d_halt[i],  (m_state[i] == M_HALT) ? 1 : 0);
        chk($sformatf("trig%0d", i),   d_trig[i],  m_trig[i]);
        chk($sformatf("passc%0d", i),  d_passc[i], m_pass[i]);
        chk($sformatf("failc%0d", i),  d_failc[i], m_fail[i]);
        chk($sformatf("abort%0d", i),  d_abort[i], m_abort[i]);
        chk($sformatf("ffv%0d", i),    d_ffv[i],   m_ffv[i]);
        chk($sformatf("ffc%0d", i),    d_ffc[i],   m_ffc[i]);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit [19:0] dv, av, bv;
    int        busy_cycles;
    rst_n = 1'b0; en = 1'b0; dis = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Mixed disable/antecedent pattern on the DELAY=1 instance.
    step(1, 0, 1, 0, 0);
    dv = 20'h0; av = 20'h0; bv = 20'h0;
    dv[0] = 1'b1; dv[6] = 1'b1; dv[11] = 1'b1;
    av[1] = 1'b1; av[2] = 1'b1; av[6] = 1'b1; av[10] = 1'b1; av[17] = 1'b1;
    bv[2] = 1'b1; bv[3] = 1'b1; bv[6] = 1'b1; bv[17] = 1'b1;
    for (int k = 0; k < 20; k++) step(1, dv[k], 0, av[k], bv[k]);
    @(posedge clk); #3;
    chk("seq_trig1", d_trig[1], 4);
    chk("seq_pass1", d_passc[1], 2);
    chk("seq_fail1", d_failc[1], 1);
    chk("seq_abort1", d_abort[1], 1);
    chk("seq_ffc1", d_ffc[1], 18);

    // Back-to-back obligations on the DELAY=3 instance.
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    busy_cycles = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, (k < 4), 1);
      @(posedge clk); #3;
      if (busy0) busy_cycles++;
    end
    chk("burst_busy_cycles0", busy_cycles, 6);
    chk("burst_pass0", d_passc[0], 4);
    chk("burst_fail0", d_failc[0], 0);

    // Stop-on-fail: halt, frozen trigger count, then clear.
    step(1, 0, 1, 0, 1);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 1, (k != 5));
    @(posedge clk); #3;
    chk("halt_halted1", d_halt[1], 1);
    chk("halt_trig1", d_trig[1], 5);
    chk("halt_fail1", d_failc[1], 1);
    chk("halt_pass1", d_passc[1], 3);
    step(1, 0, 1, 1, 1);
    @(posedge clk); #3;
    chk("clr_halted1", d_halt[1], 0);
    chk("clr_trig1", d_trig[1], 0);
    chk("clr_fail1", d_failc[1], 0);
    chk("clr_ffv1", d_ffv[1], 0);

    // Saturation of 5-bit counters and of the cycle index.
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 40; k++) step(1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    @(posedge clk); #3;
    chk("sat_pass1", d_passc[1], 31);
    chk("sat_trig1", d_trig[1], 31);
    chk("sat_ffc1", d_ffc[1], 31);

    // enable dropped with an obligation in flight, then re-enabled while IDLE.
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    @(posedge clk); #3;
    chk("endrop_pass0", d_passc[0], 1);
    chk("endrop_trig0", d_trig[0], 1);

    // Asynchronous reset with obligations pending.
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int s = 0; s < 600; s++) begin
      if (s == 200 || s == 400) do_reset();
      step(rnd(85), rnd(6), rnd(2), rnd(50), rnd(85));
    end
    step(0, 0, 0, 0, 1);
    @(posedge clk); #3;
    chk("events_drained", ev_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/impl_checker.md
IMPL_CHECKER -- requirements
Module: impl_checker

Interface
REQ-001 SHALL have parameter DELAY, default 1, meaning the consequent offset N in "a |-> ##N b"; legal range 1..8.
REQ-002 SHALL have parameter CW, default 16, meaning the width of every counter and of the cycle index.
REQ-003 SHALL have parameter STOP_ON_FAIL, default 0; when 1, checking halts after the first failure.
REQ-004 clock  input  1  sole clock; all logic on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  checking enabled; when low, no new obligations are created.
REQ-007 disable_chk  input  1  abort; equivalent to "disable iff"; discards all pending obligations.
REQ-008 clear  input  1  synchronous clear of counters, capture registers and state.
REQ-009 a  input  1  antecedent.
REQ-010 b  input  1  consequent.
REQ-011 pass  output  1  one-cycle pulse per satisfied obligation.
REQ-012 fail  output  1  one-cycle pulse per violated obligation.
REQ-013 busy  output  1  at least one obligation pending.
REQ-014 trig_count, pass_count, fail_count, abort_count  output  CW each  saturating event counters.
REQ-015 first_fail_valid  output  1  sticky; first_fail_cycle has been captured.
REQ-016 first_fail_cycle  output  CW  cycle index of the first failing b-sample edge.
REQ-017 halted  output  1  high in state HALTED.

Function
REQ-018 SHALL keep a cycle index counting posedges since reset release or clear; the first edge is index 0; it saturates at all-ones.
REQ-019 SHALL track overlapping obligations in a DELAY-deep pending shift register, so a new obligation can start every cycle.
REQ-020 SHALL create an obligation at an edge where a=1, enable=1, disable_chk=0 and the state is RUN; trig_count increments at that edge.
REQ-021 SHALL evaluate each obligation at the edge exactly DELAY cycles after creation: b=1 gives pass and pass_count+1; b=0 gives fail and fail_count+1.
REQ-022 pass and fail SHALL be registered, asserted in the cycle following the evaluation edge, and never both high together.
REQ-023 At an edge with disable_chk=1: every pending obligation, including one maturing at that edge, SHALL be discarded; abort_count SHALL add the number discarded (saturating); no pass or fail SHALL be produced and no obligation SHALL be created.
REQ-024 enable low SHALL NOT cancel pending obligations; they still mature normally.
REQ-025 On the first fail since reset/clear, SHALL capture first_fail_cycle = index of the evaluating edge and set first_fail_valid; later fails SHALL NOT overwrite it.
REQ-026 FSM states: IDLE, RUN, HALTED.
  - IDLE to RUN when enable=1.
  - RUN to IDLE when enable=0 and busy=0.
  - RUN to HALTED on a fail when STOP_ON_FAIL=1.
  - HALTED is left only by clear or reset.
REQ-027 In HALTED: no new obligations; pending ones SHALL be discarded without counting; busy SHALL be 0.
REQ-028 Counters SHALL saturate at 2^CW-1 and never wrap.
REQ-029 clear SHALL take priority over all other inputs; the state after clear is IDLE with everything zeroed.
REQ-030 busy SHALL be the OR of the pending register, combinational from registers only.

Reset
REQ-031 reset_n low SHALL immediately and asynchronously force:
  - pending register, all counters, cycle index, first_fail_* and pass/fail to 0;
  - state to IDLE.
REQ-032 Assertion of reset_n mid-obligation SHALL discard pending obligations without counting an abort.
REQ-033 Deassertion of reset_n is synchronous to clock at the integrating level; the first edge after deassertion is index 0.

Verification
REQ-034 DELAY=1, enable=1; 20 cycles with disable_chk high at 0,6,11, a high at 1,2,6,10,17, b high at 2,3,6,17 -> trig=4, pass=2, fail=1, abort=1, first_fail_cycle=18.
REQ-035 DELAY=3; a high for 4 consecutive cycles, b always high -> 4 pass pulses in consecutive cycles, busy high 6 cycles, fail=0.
REQ-036 STOP_ON_FAIL=1, DELAY=1; a=1 every cycle, b low once at index 5 -> fail pulse once, halted=1, trig frozen at 5, then clear -> IDLE with all counters 0.
REQ-037 CW=4; 20 passing obligations -> pass_count holds 15 with no wrap.
REQ-038 reset_n pulsed low asynchronously with 2 obligations pending (DELAY=2) -> all outputs 0 before the next edge; no pass, fail or abort afterwards.
REQ-039 enable dropped with an obligation pending -> obligation still evaluated; state returns to IDLE in the cycle after busy falls.
